// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter.
//   arb_state_e     : 2-bit FSM state encoding
//   INIT/USR/POLL   : requester index constants
//   TIMEOUT_DEFAULT : default engine wait limit in cycles
package rtc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] USR  = 2'd1;
  localparam logic [1:0] POLL = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rtc_arb_pick.sv
// Combinational winner selection for the RTC bus arbiter.
// Ports:
//   req     : request bits (0 init, 1 user, 2 poll)
//   rr_poll : round-robin pointer, 1 when poll is preferred over user
//   valid   : at least one request is pending
//   idx     : index of the winning requester
module rtc_arb_pick
  import rtc_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       rr_poll,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = INIT;
    if (req[INIT]) begin
      idx = INIT;
    end else if (req[USR] && req[POLL]) begin
      // Only a user/poll conflict consults the pointer.
      idx = rr_poll ? POLL : USR;
    end else if (req[USR]) begin
      idx = USR;
    end else if (req[POLL]) begin
      idx = POLL;
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates three RTC register requesters (init, user, poll) onto a single
// bus-cycle engine. Init has fixed top priority; user and poll share
// round-robin. Each transfer: IDLE -> ISSUE (start pulse) -> WAIT (done or
// timeout) -> RESP (ack/err pulse) -> IDLE.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   req_i/wr_i           : per-requester request level and direction
//   addr_i/wdata_i       : per-requester address/write data, 8 bits each
//   ack_o/err_o          : one-cycle completion/timeout pulse per requester
//   rdata_o              : data of the last completed read
//   eng_start/wr/addr/wdata : engine command, held from ISSUE through RESP
//   eng_done/eng_rdata   : engine completion and read data
//   busy_o               : high whenever not idle
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_i,
  input  logic [2:0]  wr_i,
  input  logic [23:0] addr_i,
  input  logic [23:0] wdata_i,
  output logic [2:0]  ack_o,
  output logic [2:0]  err_o,
  output logic [7:0]  rdata_o,
  output logic        eng_start,
  output logic        eng_wr,
  output logic [7:0]  eng_addr,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata,
  output logic        busy_o
);

  localparam logic [8:0] TimeoutW = 9'(TIMEOUT);

  arb_state_e state_q, state_d;
  logic [1:0] idx_q;
  logic       ok_q;
  logic [7:0] cnt_q;
  logic       rr_poll_q;
  logic [7:0] rdata_q;
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       sel_wr;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic [8:0] cnt_inc;
  logic       tmo_hit;

  rtc_arb_pick u_pick (
    .req     (req_i),
    .rr_poll (rr_poll_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_comb begin
    sel_wr    = wr_i[0];
    sel_addr  = addr_i[7:0];
    sel_wdata = wdata_i[7:0];
    case (pick_idx)
      USR: begin
        sel_wr    = wr_i[1];
        sel_addr  = addr_i[15:8];
        sel_wdata = wdata_i[15:8];
      end
      POLL: begin
        sel_wr    = wr_i[2];
        sel_addr  = addr_i[23:16];
        sel_wdata = wdata_i[23:16];
      end
      default: ;
    endcase
  end

  // Timeout fires on the cycle whose increment would reach TIMEOUT, so the
  // err pulse lands TIMEOUT+1 cycles after the start pulse.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign tmo_hit = (cnt_inc >= TimeoutW);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (eng_done || tmo_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= INIT;
      ok_q      <= 1'b0;
      cnt_q     <= 8'h00;
      rr_poll_q <= 1'b0;
      rdata_q   <= 8'h00;
      wr_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            idx_q   <= pick_idx;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        StIssue: cnt_q <= 8'h00;
        StWait: begin
          if (cnt_q != 8'hFF) cnt_q <= cnt_inc[7:0];
          // Done takes precedence over a simultaneous timeout.
          if (eng_done) begin
            ok_q <= 1'b1;
            if (!wr_q) rdata_q <= eng_rdata;
          end else if (tmo_hit) begin
            ok_q <= 1'b0;
          end
        end
        StResp: begin
          // Hand preference to the other of user/poll once a grant completes.
          if (idx_q != INIT) rr_poll_q <= (idx_q == USR);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_o = 3'b000;
    err_o = 3'b000;
    if (state_q == StResp) begin
      if (ok_q) ack_o = 3'b001 << idx_q;
      else      err_o = 3'b001 << idx_q;
    end
  end

  assign eng_start = (state_q == StIssue);
  assign busy_o    = (state_q != StIdle);
  assign eng_wr    = wr_q;
  assign eng_addr  = addr_q;
  assign eng_wdata = wdata_q;
  assign rdata_o   = rdata_q;

endmodule
